// File: rtl/irq_controller.sv
// Interrupt controller: synchronizes and edge-detects external lines into a pending register,
// and presents the lowest-index unmasked pending source to the processor with a request/ack FSM.
module irq_controller #(
  parameter int unsigned     N         = 64,
  parameter int unsigned     NSRC      = 4,
  parameter logic [63:0]     BASE_ADDR = 64'h800,
  parameter logic [NSRC-1:0] MASK_RST  = '1
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic [N-1:0]    DM_addr,
  input  logic [N-1:0]    DM_writeData,
  input  logic            DM_writeEnable,
  input  logic            ExtIAck,
  output logic            ExtIRQ,
  output logic [3:0]      irq_id,
  output logic [NSRC-1:0] irq_pending
);

  localparam logic [N-1:0] MASK_ADDR = N'(BASE_ADDR);
  localparam logic [N-1:0] CLR_ADDR  = N'(BASE_ADDR + 64'd8);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACKWAIT = 2'd2
  } state_e;

  logic [NSRC-1:0] sync1_q, sync1_d;
  logic [NSRC-1:0] sync2_q, sync2_d;
  logic [NSRC-1:0] prev_q, prev_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q, mask_d;
  state_e          state_q, state_d;
  logic [3:0]      id_q, id_d;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] store_clr;
  logic [NSRC-1:0] ack_clr;
  logic [3:0]      enc_id;
  logic            mask_we;
  logic            clr_we;

  // Only the low NSRC data bits reach any register.
  logic unused_wdata;
  assign unused_wdata = ^DM_writeData[N-1:NSRC];

  // Synchronizer, previous-sample stage and rising-edge detect.
  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  assign rise = sync2_q & ~prev_q;

  // Store decode: exact address match with the write strobe.
  assign mask_we   = DM_writeEnable && (DM_addr == MASK_ADDR);
  assign clr_we    = DM_writeEnable && (DM_addr == CLR_ADDR);
  assign store_clr = clr_we ? DM_writeData[NSRC-1:0] : '0;
  assign active    = pending_q & mask_q;

  always_comb begin
    mask_d = mask_q;
    if (mask_we) begin
      mask_d = DM_writeData[NSRC-1:0];
    end
  end

  // Lowest set index wins: scan downward so the last hit is the smallest.
  always_comb begin
    enc_id = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        enc_id = 4'(i);
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ack_clr = '0;
    unique case (state_q)
      IDLE: begin
        if (|active) begin
          state_d = REQ;
          id_d    = enc_id;
        end
      end
      REQ: begin
        if (ExtIAck) begin
          state_d = ACKWAIT;
          for (int i = 0; i < NSRC; i++) begin
            ack_clr[i] = (id_q == 4'(i));
          end
        end
      end
      ACKWAIT: begin
        if (!ExtIAck) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new edge overrides any clear (ack or store) landing on the same bit.
  assign pending_d = (pending_q & ~(store_clr | ack_clr)) | rise;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values,
  // independent of statement order.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= MASK_RST;
      state_q   <= IDLE;
      id_q      <= 4'd0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      state_q   <= state_d;
      id_q      <= id_d;
    end
  end

  assign ExtIRQ      = (state_q == REQ);
  assign irq_id      = ExtIRQ ? id_q : 4'd0;
  assign irq_pending = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller; a negedge monitor pops expected irq_id values
// from a scoreboard queue on every rising ExtIRQ.
module tb_irq_controller;

  localparam int NSRC = 4;

  logic            CLOCK_50 = 1'b0;
  logic            reset;
  logic [NSRC-1:0] irq_in;
  logic [63:0]     DM_addr;
  logic [63:0]     DM_writeData;
  logic            DM_writeEnable;
  logic            ExtIAck;
  logic            ExtIRQ;
  logic [3:0]      irq_id;
  logic [NSRC-1:0] irq_pending;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;
  logic       prev_irq    = 1'b0;

  irq_controller dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .irq_in        (irq_in),
    .DM_addr       (DM_addr),
    .DM_writeData  (DM_writeData),
    .DM_writeEnable(DM_writeEnable),
    .ExtIAck       (ExtIAck),
    .ExtIRQ        (ExtIRQ),
    .irq_id        (irq_id),
    .irq_pending   (irq_pending)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Every new request must match the oldest expected source id.
  always @(negedge CLOCK_50) begin
    if (ExtIRQ && !prev_irq) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_req: got irq_id=%0d, no request expected", irq_id);
      end else begin
        mon_exp = exp_q.pop_front();
        if (irq_id !== mon_exp) begin
          miscompares++;
          $display("FAIL req_id: got irq_id=%0d, want %0d", irq_id, mon_exp);
        end
      end
    end
    prev_irq = ExtIRQ;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t want finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic store(input logic [63:0] addr, input logic [63:0] data);
    DM_addr        = addr;
    DM_writeData   = data;
    DM_writeEnable = 1'b1;
    @(negedge CLOCK_50);
    DM_writeEnable = 1'b0;
    DM_addr        = '0;
    DM_writeData   = '0;
  endtask

  task automatic wait_irq(input string name);
    int n = 0;
    while (!ExtIRQ && n < 30) begin
      @(negedge CLOCK_50);
      n++;
    end
    vectors++;
    if (ExtIRQ !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_timeout: ExtIRQ=%b after 30 cycles, want 1", name, ExtIRQ);
    end
  endtask

  task automatic do_ack();
    ExtIAck = 1'b1;
    @(negedge CLOCK_50);
    ExtIAck = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    irq_in         = '0;
    DM_addr        = '0;
    DM_writeData   = '0;
    DM_writeEnable = 1'b0;
    ExtIAck        = 1'b0;
    #2;
    vectors++;
    if ({ExtIRQ, irq_id, irq_pending} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got irq=%b id=%0d pend=%b, want 0 0 0000",
               ExtIRQ, irq_id, irq_pending);
    end
    cyc(2);
    reset = 1'b0;
    cyc(2);
    vectors++;
    if ({ExtIRQ, irq_id, irq_pending} !== 9'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got irq=%b id=%0d pend=%b, want 0 0 0000",
               ExtIRQ, irq_id, irq_pending);
    end
  endtask

  task automatic test_single();
    irq_in[2] = 1'b1;
    cyc(2);
    vectors++;
    if (irq_pending !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_pend_early: got %b after k+1, want 0000", irq_pending);
    end
    cyc(1);
    vectors++;
    if (irq_pending !== 4'b0100 || ExtIRQ !== 1'b0) begin
      miscompares++;
      $display("FAIL single_pend: got pend=%b irq=%b after k+2, want 0100 0", irq_pending, ExtIRQ);
    end
    exp_q.push_back(4'd2);
    cyc(1);
    vectors++;
    if (ExtIRQ !== 1'b1 || irq_id !== 4'd2) begin
      miscompares++;
      $display("FAIL single_req: got irq=%b id=%0d after k+3, want 1 2", ExtIRQ, irq_id);
    end
    cyc(3);
    vectors++;
    if (ExtIRQ !== 1'b1 || irq_id !== 4'd2) begin
      miscompares++;
      $display("FAIL single_hold: got irq=%b id=%0d, want 1 2", ExtIRQ, irq_id);
    end
    do_ack();
    vectors++;
    if (irq_pending !== 4'b0000 || ExtIRQ !== 1'b0 || irq_id !== 4'd0) begin
      miscompares++;
      $display("FAIL single_ack: got pend=%b irq=%b id=%0d, want 0000 0 0",
               irq_pending, ExtIRQ, irq_id);
    end
    irq_in = '0;
    cyc(4);
  endtask

  task automatic test_priority();
    irq_in = 4'b1010;
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd3);
    wait_irq("prio1");
    vectors++;
    if (irq_id !== 4'd1) begin
      miscompares++;
      $display("FAIL prio_first: got id=%0d, want 1", irq_id);
    end
    do_ack();
    vectors++;
    if (irq_pending !== 4'b1000) begin
      miscompares++;
      $display("FAIL prio_after_ack: got pend=%b, want 1000", irq_pending);
    end
    wait_irq("prio2");
    vectors++;
    if (irq_id !== 4'd3) begin
      miscompares++;
      $display("FAIL prio_second: got id=%0d, want 3", irq_id);
    end
    do_ack();
    vectors++;
    if (irq_pending !== 4'b0000) begin
      miscompares++;
      $display("FAIL prio_drain: got pend=%b, want 0000", irq_pending);
    end
    irq_in = '0;
    cyc(4);
  endtask

  task automatic test_mask();
    store(64'h800, 64'hE);
    irq_in[0] = 1'b1;
    cyc(6);
    vectors++;
    if (irq_pending !== 4'b0001 || ExtIRQ !== 1'b0) begin
      miscompares++;
      $display("FAIL mask_block: got pend=%b irq=%b, want 0001 0", irq_pending, ExtIRQ);
    end
    ExtIAck = 1'b1;
    cyc(1);
    ExtIAck = 1'b0;
    cyc(1);
    vectors++;
    if (irq_pending !== 4'b0001 || ExtIRQ !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ack_ignored: got pend=%b irq=%b, want 0001 0", irq_pending, ExtIRQ);
    end
    exp_q.push_back(4'd0);
    store(64'h800, 64'hF);
    wait_irq("unmask");
    vectors++;
    if (irq_id !== 4'd0) begin
      miscompares++;
      $display("FAIL unmask_id: got id=%0d, want 0", irq_id);
    end
    store(64'h800, 64'h0);
    store(64'h808, 64'h1);
    vectors++;
    if (ExtIRQ !== 1'b1 || irq_id !== 4'd0 || irq_pending !== 4'b0000) begin
      miscompares++;
      $display("FAIL no_withdraw: got irq=%b id=%0d pend=%b, want 1 0 0000",
               ExtIRQ, irq_id, irq_pending);
    end
    do_ack();
    vectors++;
    if (ExtIRQ !== 1'b0) begin
      miscompares++;
      $display("FAIL withdraw_ack: got irq=%b, want 0", ExtIRQ);
    end
    store(64'h800, 64'hF);
    irq_in = '0;
    cyc(4);
  endtask

  task automatic test_clear_collision();
    store(64'h800, 64'h0);
    irq_in[0] = 1'b1;
    cyc(4);
    vectors++;
    if (irq_pending !== 4'b0001) begin
      miscompares++;
      $display("FAIL coll_setup: got pend=%b, want 0001", irq_pending);
    end
    irq_in[0] = 1'b0;
    cyc(4);
    irq_in[0] = 1'b1;
    cyc(2);
    store(64'h808, 64'h1);
    vectors++;
    if (irq_pending !== 4'b0001) begin
      miscompares++;
      $display("FAIL set_wins_clear: got pend=%b, want 0001", irq_pending);
    end
    irq_in[2] = 1'b1;
    cyc(4);
    store(64'h808, 64'h4);
    vectors++;
    if (irq_pending !== 4'b0001) begin
      miscompares++;
      $display("FAIL clear_bit2: got pend=%b, want 0001", irq_pending);
    end
    store(64'h810, 64'h1);
    vectors++;
    if (irq_pending !== 4'b0001) begin
      miscompares++;
      $display("FAIL other_addr: got pend=%b, want 0001", irq_pending);
    end
    store(64'h808, 64'h1);
    vectors++;
    if (irq_pending !== 4'b0000) begin
      miscompares++;
      $display("FAIL clear_bit0: got pend=%b, want 0000", irq_pending);
    end
    irq_in = '0;
    store(64'h800, 64'hF);
    cyc(4);
  endtask

  task automatic test_reset_req();
    irq_in[1] = 1'b1;
    exp_q.push_back(4'd1);
    wait_irq("rst_req");
    store(64'h800, 64'h0);
    irq_in = 4'b1010;
    cyc(1);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (ExtIRQ !== 1'b0 || irq_pending !== 4'b0000 || irq_id !== 4'd0) begin
      miscompares++;
      $display("FAIL async_reset: got irq=%b pend=%b id=%0d, want 0 0000 0",
               ExtIRQ, irq_pending, irq_id);
    end
    @(negedge CLOCK_50);
    reset = 1'b0;
    // Lines held high through release each yield one request; MASK is back to all ones.
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd3);
    wait_irq("held1");
    do_ack();
    wait_irq("held3");
    do_ack();
    cyc(20);
    vectors++;
    if (exp_q.size() != 0 || ExtIRQ !== 1'b0 || irq_pending !== 4'b0000) begin
      miscompares++;
      $display("FAIL held_once: got left=%0d irq=%b pend=%b, want 0 0 0000",
               exp_q.size(), ExtIRQ, irq_pending);
    end
    irq_in = '0;
    cyc(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_clear_collision();
    test_reset_req();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The block SHALL have parameter N, default 64, giving the width of the data-memory address and write-data bus.
REQ-002 The block SHALL have parameter NSRC, default 4 (legal range 1..16), giving the number of external interrupt sources.
REQ-003 The block SHALL have parameter BASE_ADDR, default 64'h800, giving the byte address of the MASK register; the CLEAR register SHALL be at BASE_ADDR+8.
REQ-004 The block SHALL have parameter MASK_RST, default all ones, giving the MASK register value at reset.
REQ-005 Port CLOCK_50 SHALL be an input, 1 bit wide: the single clock, with all state on its rising edge.
REQ-006 Port reset SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-007 Port irq_in SHALL be an input, NSRC bits wide: external interrupt lines, asynchronous to CLOCK_50, rising-edge significant.
REQ-008 Port DM_addr SHALL be an input, N bits wide: processor data-memory byte address.
REQ-009 Port DM_writeData SHALL be an input, N bits wide: processor store data.
REQ-010 Port DM_writeEnable SHALL be an input, 1 bit wide: processor store strobe, one cycle per store.
REQ-011 Port ExtIAck SHALL be an input, 1 bit wide: interrupt acknowledge from the processor controller.
REQ-012 Port ExtIRQ SHALL be an output, 1 bit wide: interrupt request to the processor.
REQ-013 Port irq_id SHALL be an output, 4 bits wide: index of the source being requested, valid while ExtIRQ=1.
REQ-014 Port irq_pending SHALL be an output, NSRC bits wide: current pending register, for debug.

Function
REQ-015 Each irq_in bit SHALL pass through a two-flop synchronizer followed by a previous-sample flop used for rising-edge detection.
REQ-016 A synchronized 0->1 transition SHALL set the corresponding pending bit, and pending SHALL remain set until it is cleared.
- Latency: irq_in rising before clock edge k (setup met) -> pending set after edge k+2.
- ExtIRQ rises after edge k+3 when the source is unmasked and the FSM is in IDLE.
REQ-017 Store decode SHALL require DM_writeEnable=1 and an exact match of DM_addr to the register address.
- MASK <= DM_writeData[NSRC-1:0].
- CLEAR: pending <= pending & ~DM_writeData[NSRC-1:0].
- Stores to any other address SHALL be ignored.
REQ-018 The FSM SHALL have the three states IDLE, REQ and ACKWAIT.
- IDLE: ExtIRQ=0. If (pending & MASK) != 0, go to REQ and latch irq_id = lowest-index set bit of (pending & MASK).
- REQ: ExtIRQ=1 and irq_id held. On ExtIAck=1, clear pending[irq_id] and go to ACKWAIT.
- ACKWAIT: ExtIRQ=0. When ExtIAck=0, go to IDLE. Re-arbitration happens only from IDLE.
REQ-019 Once in REQ, a MASK write or CLEAR of the requested source SHALL NOT retract ExtIRQ or change irq_id before ExtIAck (no spurious withdrawal).
REQ-020 When a set event and a clear event hit the same pending bit in the same cycle, set SHALL win; the clear event may come from an ack or from a CLEAR store.
REQ-021 Edges on masked sources SHALL still set pending; unmasking later SHALL raise a request from IDLE.
REQ-022 ExtIAck=1 while in IDLE SHALL be ignored.
REQ-023 irq_id bits above the width of the source index SHALL be 0, and irq_id SHALL read 0 in IDLE and ACKWAIT.

Reset
REQ-024 Reset SHALL act immediately, including mid-handshake, and set the following values.
- Synchronizer and previous-sample flops = 0.
- pending = 0.
- MASK = MASK_RST.
- FSM = IDLE.
- ExtIRQ = 0, irq_id = 0, irq_pending = 0.
REQ-025 A line held high through reset release SHALL produce exactly one pending event after release.

Verification
REQ-026 The bench SHALL cover the following directed scenarios.
- Single event: irq_in[2] rises before edge k -> irq_pending=4'b0100 after k+2; ExtIRQ=1 with irq_id=2 after k+3; ExtIAck pulse -> pending 0, ExtIRQ=0.
- Priority: irq_in[3] and irq_in[1] rise together -> irq_id=1 first; after ack and ExtIAck=0, a second request with irq_id=3.
- Mask: store 4'b1110 to 0x800, then irq_in[0] rises -> pending=4'b0001 with ExtIRQ=0; store 4'b1111 -> ExtIRQ=1, irq_id=0.
- CLEAR and collision: a store of 4'b0001 to 0x808 in the same cycle as a new edge on source 0 -> bit 0 stays set. A CLEAR of a pending-only bit -> the bit is cleared.
- Reset in REQ: reset asserted while ExtIRQ=1 -> ExtIRQ=0, pending=0, MASK=4'b1111 with no clock edge needed.
- Line high at reset release -> exactly one request; a steady-high line afterward -> no further requests.
